// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and RAM geometry for the CPU memory path
package cpu_mem_pkg;
  localparam int MEM_DEPTH = 512;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: 4-bit loadable down-counter with zero flag for ACCESS wait states
module wait_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 4'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: MAR/MDR initiator sequencing setup, strobe and hold cycles to the word RAM
module mem_bus_master
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_DEPTH  = MEM_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] wdata_in,
  output logic [WORD_W-1:0] rdata_out,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);
  state_t state;
  logic [WORD_W-1:0] mar, mdr;
  logic is_wr, wait_zero, one_req, in_range;
  assign one_req   = req_rd ^ req_wr;
  assign in_range  = addr_in < WORD_W'(ADDR_DEPTH);
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  wait_counter u_wait (
    .clk      (clk),
    .clr      (clr),
    .load     (state == SETUP),
    .dec      (state == ACCESS),
    .load_val (4'(WAIT_STATES)),
    .zero     (wait_zero)
  );
  // strobes are registered alongside the state so they track it exactly
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      rdata_out <= '0;
      is_wr     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE:
          if ((req_rd && req_wr) || (one_req && !in_range)) err <= 1'b1;
          else if (one_req) begin
            mar   <= addr_in;
            mdr   <= req_wr ? wdata_in : mdr;
            is_wr <= req_wr;
            busy  <= 1'b1;
            state <= SETUP;
          end
        SETUP: begin
          mem_read  <= !is_wr;
          mem_write <= is_wr;
          state     <= ACCESS;
        end
        ACCESS:
          if (wait_zero) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b1;
            mdr       <= is_wr ? mdr : mem_rdata;
            rdata_out <= is_wr ? rdata_out : mem_rdata;
            state     <= DONE;
          end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the unified 512x32 word RAM.
- Owns the MAR/MDR pair and accepts single-word read/write requests from the control unit.
- Sequences the RAM's level-sensitive read/write strobes with address and data setup and hold cycles, plus a programmable wait-state count.
- Returns read data and a one-cycle done pulse to the datapath.

Parameters:
ADDR_DEPTH, 512, number of valid word addresses; any address >= ADDR_DEPTH is rejected.
WAIT_STATES, 1, extra ACCESS cycles after the first (legal range 0..15); the strobe is held WAIT_STATES+1 cycles.

Ports:
clk  in  1  system clock; all state changes on rising edge.
clr  in  1  synchronous, active-high reset.
req_rd  in  1  read request; sampled only in IDLE.
req_wr  in  1  write request; sampled only in IDLE.
addr_in  in  32  word address; latched into MAR on an accepted request.
wdata_in  in  32  write data; latched into MDR on an accepted write.
rdata_out  out  32  last completed read data; holds until the next read completes.
done  out  1  one-cycle pulse when an access completes.
busy  out  1  high in every state except IDLE.
err  out  1  one-cycle pulse when a request is rejected.
mem_addr  out  32  RAM address; equals MAR.
mem_wdata  out  32  RAM data_in; equals MDR.
mem_rdata  in  32  RAM data_out.
mem_read  out  1  RAM read strobe.
mem_write  out  1  RAM write strobe.

Behaviour:
- Reset (clr high at an edge):
  - state <= IDLE; MAR, MDR, rdata_out <= 0.
  - done, err, mem_read, mem_write, busy <= 0.
  - Overrides any in-flight access: the strobe drops at that edge and no done is issued.
- Strobe outputs:
  - All outputs are registered; the strobes are decoded from the state register, with no combinational path from req_* to any strobe.
- IDLE:
  - Both req_rd and req_wr high: err pulse next cycle; no latch, no access; stay IDLE.
  - Exactly one request high and addr_in >= ADDR_DEPTH: err pulse; stay IDLE; MAR/MDR unchanged.
  - Otherwise: MAR <= addr_in. For a write, MDR <= wdata_in. Latch the direction; go to SETUP.
- SETUP (1 cycle):
  - mem_addr/mem_wdata stable; both strobes low.
  - Load wait counter <= WAIT_STATES; go to ACCESS.
- ACCESS (WAIT_STATES+1 cycles):
  - Assert mem_read or mem_write per the latched direction.
  - Counter decrements each cycle; leave ACCESS when the counter is 0.
  - Read: on the final ACCESS edge, MDR <= mem_rdata.
  - Go to DONE.
- DONE (1 cycle):
  - Strobes low; MAR/MDR held (address hold for the RAM's level write).
  - done = 1. For a read, rdata_out = MDR.
  - Go to IDLE.
- Latency: request sampled in cycle 0 -> done high in cycle WAIT_STATES+3. A new request may be sampled in the cycle after done.
- Ignored inputs: requests while busy are ignored (not queued), and no err is raised for them.
- Invariant: mem_read and mem_write are never high together, and neither is high in IDLE, SETUP or DONE.
- Address width: MAR is full 32 bits; the range check is unsigned.

Decomposition:
- Shared package cpu_mem_pkg: state enum (IDLE, SETUP, ACCESS, DONE), MEM_DEPTH=512, WORD_W=32.
- One natural sub-module: wait_counter (4-bit loadable down-counter with zero flag).

Test Plan:
- clr held 2 cycles -> all outputs 0, busy=0; then clr low with no request -> outputs stay 0.
- WAIT_STATES=1: req_wr, addr=94, wdata=0x0000000D -> mem_write high exactly cycles 2-3, done at cycle 4; then req_rd addr=94 -> rdata_out=0x0000000D at done, mem_read high 2 cycles.
- req_rd with addr=512 -> err pulse 1 cycle, busy stays 0, no strobe, MAR unchanged; addr=511 -> accepted.
- req_rd and req_wr both high -> err pulse, no strobe; req_wr pulsed while busy -> ignored, single done.
- clr asserted during ACCESS of a write -> strobe low after that edge, no done, state IDLE; a following read completes normally.
- WAIT_STATES=0 build: read addr=0 -> mem_read high exactly 1 cycle, done 3 cycles after the request; back-to-back reads give done every 4 cycles.
